// File: rtl/scope_pkg.sv
// Shared scope definitions: capture FSM state encoding, trigger mode codes and
// the default trace geometry that the VDU trace buffers are built around.
package scope_pkg;

    // Capture sequencer state encoding (also visible on state_o)
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArmed   = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StHoldoff = 2'd3;

    // Trigger modes
    localparam logic [1:0] ModeAuto   = 2'd0;
    localparam logic [1:0] ModeNormal = 2'd1;
    localparam logic [1:0] ModeSingle = 2'd2;
    localparam logic [1:0] ModeStop   = 2'd3;

    // Trace geometry shared with the VDU
    localparam int unsigned DefDepth       = 640;
    localparam int unsigned DefAw          = 10;
    localparam int unsigned DefDw          = 9;
    localparam int unsigned DefAutoTimeout = 2048;
    localparam int unsigned DefHw          = 16;

endpackage

// File: rtl/capture_sequencer_if.sv
// Capture sequencer bundle: sample input, trigger/run control and the trace
// buffer write port.
//   master : sample source / front-panel control side
//   slave  : capture_sequencer
interface capture_sequencer_if
    import scope_pkg::*;
#(
    parameter int unsigned AW = DefAw,
    parameter int unsigned DW = DefDw,
    parameter int unsigned HW = DefHw
);
    // Sample source and control
    logic          sample_valid;
    logic [DW-1:0] ch1_in;
    logic [DW-1:0] ch2_in;
    logic [DW-1:0] trig_level;
    logic          trig_src;
    logic          trig_slope;
    logic [1:0]    mode;
    logic          arm;
    logic          abort;
    logic [HW-1:0] holdoff;
    // Trace buffer write port and status
    logic [AW-1:0] wraddr;
    logic [DW-1:0] wrdata1;
    logic [DW-1:0] wrdata2;
    logic          we;
    logic [1:0]    state_o;
    logic          triggered;
    logic          frame_done;

    modport master (
        output sample_valid, ch1_in, ch2_in, trig_level, trig_src, trig_slope, mode, arm,
               abort, holdoff,
        input  wraddr, wrdata1, wrdata2, we, state_o, triggered, frame_done
    );

    modport slave (
        input  sample_valid, ch1_in, ch2_in, trig_level, trig_src, trig_slope, mode, arm,
               abort, holdoff,
        output wraddr, wrdata1, wrdata2, we, state_o, triggered, frame_done
    );

endinterface

// File: rtl/trig_detect.sv
// Edge trigger detector for the selected channel.
//   sclk, rst : clock, asynchronous active-high reset
//   en_i      : detector armed; while low the history is discarded
//   valid_i   : cur_i is an accepted sample this cycle
//   slope_i   : 0 = rising, 1 = falling
//   cur_i     : current sample of the selected channel (unsigned)
//   level_i   : trigger threshold (unsigned)
//   hit_o     : combinational, high for the accepted sample that crosses the level
module trig_detect #(
    parameter int unsigned DW = 9
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic          slope_i,
    input  logic [DW-1:0] cur_i,
    input  logic [DW-1:0] level_i,
    output logic          hit_o
);

    logic [DW-1:0] prev_q;
    logic          prev_valid_q;
    logic          cur_above;
    logic          prev_above;
    logic          crossed;

    // History is dropped whenever disarmed, so the first sample after arming only loads prev.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (!en_i) begin
            prev_valid_q <= 1'b0;
        end else if (valid_i) begin
            prev_q       <= cur_i;
            prev_valid_q <= 1'b1;
        end
    end

    always_comb begin
        cur_above  = (cur_i >= level_i);
        prev_above = (prev_q >= level_i);
        crossed    = slope_i ? (prev_above && !cur_above) : (!prev_above && cur_above);
        hit_o      = en_i && valid_i && prev_valid_q && crossed;
    end

endmodule

// File: rtl/capture_sequencer.sv
// Trigger and capture controller for the VDU trace buffers. Waits for a trigger on
// the selected channel (or an auto-mode timeout), writes DEPTH sample pairs at
// addresses 0..DEPTH-1, then skips `holdoff` accepted samples before re-arming.
//   sclk, rst : sampling clock, asynchronous active-high reset
//   cap_io    : sample/control inputs and registered write port (slave modport)
module capture_sequencer
    import scope_pkg::*;
#(
    parameter int unsigned DEPTH        = DefDepth,
    parameter int unsigned AW           = DefAw,
    parameter int unsigned DW           = DefDw,
    parameter int unsigned AUTO_TIMEOUT = DefAutoTimeout,
    parameter int unsigned HW           = DefHw
) (
    input logic                sclk,
    input logic                rst,
    capture_sequencer_if.slave cap_io
);

    localparam int unsigned    TW          = $clog2(AUTO_TIMEOUT) + 1;
    localparam logic [AW-1:0]  LastAddr    = AW'(DEPTH - 1);
    localparam logic [TW-1:0]  TimeoutLast = TW'(AUTO_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] wraddr_q, wraddr_d;
    logic [DW-1:0] wrdata1_q, wrdata1_d;
    logic [DW-1:0] wrdata2_q, wrdata2_d;
    logic          we_q, we_d;
    logic          trig_q, trig_d;
    logic          done_q, done_d;

    logic          armed;
    logic          trig_hit;
    logic          write;
    logic [DW-1:0] cur_sample;

    assign armed      = (state_q == StArmed);
    assign cur_sample = cap_io.trig_src ? cap_io.ch2_in : cap_io.ch1_in;

    trig_detect #(
        .DW(DW)
    ) u_trig_detect (
        .sclk    (sclk),
        .rst     (rst),
        .en_i    (armed),
        .valid_i (cap_io.sample_valid),
        .slope_i (cap_io.trig_slope),
        .cur_i   (cur_sample),
        .level_i (cap_io.trig_level),
        .hit_o   (trig_hit)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        hold_d    = hold_q;
        wraddr_d  = wraddr_q;
        wrdata1_d = wrdata1_q;
        wrdata2_d = wrdata2_q;
        we_d      = 1'b0;
        trig_d    = trig_q;
        done_d    = 1'b0;
        write     = 1'b0;

        if (cap_io.abort) begin
            // Partial frame stays in the buffer; write data is simply held.
            state_d  = StIdle;
            addr_d   = '0;
            tmo_d    = '0;
            hold_d   = '0;
            wraddr_d = '0;
            trig_d   = 1'b0;
        end else begin
            // The cycle after the final write: announce the frame and park the address.
            if (we_q && (wraddr_q == LastAddr)) begin
                done_d   = 1'b1;
                wraddr_d = '0;
            end

            case (state_q)
                StIdle: begin
                    if (cap_io.arm && (cap_io.mode != ModeStop)) begin
                        state_d = StArmed;
                        mode_d  = cap_io.mode;
                        tmo_d   = '0;
                    end
                end
                StArmed: begin
                    if (cap_io.sample_valid) begin
                        if (trig_hit) begin
                            write   = 1'b1;
                            trig_d  = 1'b1;
                            state_d = StCapture;
                            tmo_d   = '0;
                        end else if (mode_q == ModeAuto) begin
                            if (tmo_q >= TimeoutLast) begin
                                write   = 1'b1;
                                trig_d  = 1'b0;
                                state_d = StCapture;
                                tmo_d   = '0;
                            end else begin
                                tmo_d = tmo_q + 1'b1;
                            end
                        end
                    end
                end
                StCapture: begin
                    write = cap_io.sample_valid;
                end
                default: begin // StHoldoff
                    if (hold_q >= cap_io.holdoff) begin
                        state_d = (mode_q == ModeSingle) ? StIdle : StArmed;
                        hold_d  = '0;
                        tmo_d   = '0;
                    end else if (cap_io.sample_valid) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            endcase

            // addr_q is always 0 in ARMED, so the starting sample lands at address 0.
            if (write) begin
                we_d      = 1'b1;
                wraddr_d  = addr_q;
                wrdata1_d = cap_io.ch1_in;
                wrdata2_d = cap_io.ch2_in;
                if (addr_q == LastAddr) begin
                    addr_d  = '0;
                    state_d = StHoldoff;
                    hold_d  = '0;
                    trig_d  = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= ModeAuto;
            addr_q    <= '0;
            tmo_q     <= '0;
            hold_q    <= '0;
            wraddr_q  <= '0;
            wrdata1_q <= '0;
            wrdata2_q <= '0;
            we_q      <= 1'b0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            wraddr_q  <= wraddr_d;
            wrdata1_q <= wrdata1_d;
            wrdata2_q <= wrdata2_d;
            we_q      <= we_d;
            trig_q    <= trig_d;
            done_q    <= done_d;
        end
    end

    assign cap_io.wraddr     = wraddr_q;
    assign cap_io.wrdata1    = wrdata1_q;
    assign cap_io.wrdata2    = wrdata2_q;
    assign cap_io.we         = we_q;
    assign cap_io.state_o    = state_q;
    assign cap_io.triggered  = trig_q;
    assign cap_io.frame_done = done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios with randomized sample data,
// checked against a frame model built from the accepted-sample history.
module tb_capture_sequencer;
    import scope_pkg::*;

    localparam int unsigned DEPTH = 640;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 9;
    localparam int unsigned AUTO_TIMEOUT = 2048;
    localparam int unsigned HW = 16;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    capture_sequencer_if #(.AW(AW), .DW(DW), .HW(HW)) cap ();

    capture_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .AUTO_TIMEOUT(AUTO_TIMEOUT), .HW(HW)
    ) u_dut (
        .sclk   (sclk),
        .rst    (rst),
        .cap_io (cap)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observed write log, appended only by the monitor
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] w1_q[$];
    logic [DW-1:0] w2_q[$];
    logic          wt_q[$];
    int            done_cnt = 0;
    int            consec_cnt = 0;
    bit            prev_we = 1'b0;

    always @(negedge sclk) begin
        if (!rst) begin
            if (cap.we === 1'b1) begin
                if (prev_we) consec_cnt++;
                wa_q.push_back(cap.wraddr);
                w1_q.push_back(cap.wrdata1);
                w2_q.push_back(cap.wrdata2);
                wt_q.push_back(cap.triggered);
            end
            prev_we = (cap.we === 1'b1);
            if (cap.frame_done === 1'b1) done_cnt++;
        end else begin
            prev_we = 1'b0;
        end
    end

    // Reference model: accepted samples since arming, and where the frame starts
    logic [DW-1:0] acc1[$];
    logic [DW-1:0] acc2[$];
    int            m_start;
    logic          m_trig;
    bit            m_src, m_slope, m_auto;
    logic [DW-1:0] m_level;
    int            base_w, base_done, base_consec;
    int            ramp_off, n_high;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic bit crosses(input logic [DW-1:0] p, input logic [DW-1:0] c);
        if (m_slope) return (p >= m_level) && (c < m_level);
        return (p < m_level) && (c >= m_level);
    endfunction

    task automatic push_sample(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n;
        acc1.push_back(a);
        acc2.push_back(b);
        n = acc1.size() - 1;
        if (m_start < 0) begin
            if (n >= 1 && crosses(m_src ? acc2[n-1] : acc1[n-1], m_src ? b : a)) begin
                m_start = n;
                m_trig  = 1'b1;
            end else if (m_auto && n == int'(AUTO_TIMEOUT) - 1) begin
                m_start = n;
                m_trig  = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge sclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cap.sample_valid = 1'b0;
            cap.ch1_in = DW'($urandom);
            cap.ch2_in = DW'($urandom);
            cyc();
        end
    endtask

    task automatic send_sample(input logic [DW-1:0] a, input logic [DW-1:0] b);
        cap.sample_valid = 1'b1;
        cap.ch1_in = a;
        cap.ch2_in = b;
        push_sample(a, b);
        cyc();
        cap.sample_valid = 1'b0;
    endtask

    task automatic start_run(input bit src, input bit slope, input logic [DW-1:0] level,
                             input logic [1:0] mode, input logic [HW-1:0] hold);
        acc1.delete();
        acc2.delete();
        m_start = -1;
        m_trig = 1'b0;
        m_src = src;
        m_slope = slope;
        m_level = level;
        m_auto = (mode == ModeAuto);
        base_w = wa_q.size();
        base_done = done_cnt;
        base_consec = consec_cnt;
        cap.trig_src = src;
        cap.trig_slope = slope;
        cap.trig_level = level;
        cap.mode = mode;
        cap.holdoff = hold;
        cap.arm = 1'b1;
        cyc();
        cap.arm = 1'b0;
        chk("arm->ARMED", cap.state_o, StArmed);
    endtask

    // kind 0: ramp on ch1, 1: ch2 step high->50, 2: constant 10 on ch1. gap<0: random 0..2
    task automatic feed(input int kind, input int gap, input int target);
        logic [DW-1:0] a, b;
        int k;
        for (int i = 0; i < 4000; i++) begin
            k = acc1.size();
            case (kind)
                0: begin a = DW'(ramp_off + k); b = DW'($urandom); end
                1: begin a = DW'($urandom); b = (k < n_high) ? DW'(200) : DW'(50); end
                default: begin a = DW'(10); b = DW'($urandom); end
            endcase
            send_sample(a, b);
            if (m_start >= 0 && acc1.size() >= m_start + target) break;
            idle((gap < 0) ? int'($urandom_range(0, 2)) : gap);
        end
    endtask

    task automatic check_frame(input string tag);
        int bad = 0;
        chk({tag, " write count"}, wa_q.size() - base_w, DEPTH);
        for (int j = 0; j < int'(DEPTH); j++) begin
            if (base_w + j >= wa_q.size() || m_start < 0) bad++;
            else if (wa_q[base_w+j] !== AW'(j) || w1_q[base_w+j] !== acc1[m_start+j]
                     || w2_q[base_w+j] !== acc2[m_start+j]) bad++;
        end
        chk({tag, " frame contents bad writes"}, bad, 0);
        chk({tag, " triggered"}, (wt_q.size() > base_w) ? wt_q[base_w] : 1'bx, m_trig);
        chk({tag, " frame_done pulses"}, done_cnt - base_done, 1);
        chk({tag, " wraddr parked"}, cap.wraddr, 0);
    endtask

    task automatic holdoff_phase(input string tag, input int n, input logic [1:0] exp_state);
        for (int i = 0; i < n; i++) begin
            cap.sample_valid = 1'b1;
            cap.ch1_in = DW'($urandom);
            cap.ch2_in = DW'($urandom);
            cyc();
            chk({tag, " in holdoff"}, cap.state_o, StHoldoff);
            idle(1);
        end
        chk({tag, " state after holdoff"}, cap.state_o, exp_state);
        chk({tag, " no holdoff writes"}, wa_q.size() - base_w, DEPTH);
    endtask

    initial begin
        cap.sample_valid = 1'b0;
        cap.ch1_in = '0;
        cap.ch2_in = '0;
        cap.trig_level = '0;
        cap.trig_src = 1'b0;
        cap.trig_slope = 1'b0;
        cap.mode = ModeNormal;
        cap.arm = 1'b0;
        cap.abort = 1'b0;
        cap.holdoff = '0;

        // Reset state
        repeat (3) @(posedge sclk);
        #2;
        chk("reset we", cap.we, 0);
        chk("reset state", cap.state_o, StIdle);
        rst = 1'b0;
        idle(2);
        chk("post-reset wraddr", cap.wraddr, 0);
        chk("post-reset wrdata1", cap.wrdata1, 0);
        chk("post-reset wrdata2", cap.wrdata2, 0);
        chk("post-reset triggered", cap.triggered, 0);
        chk("post-reset frame_done", cap.frame_done, 0);
        chk("post-reset state", cap.state_o, StIdle);

        // Normal, rising on ch1 ramp, valid every other cycle; mode changed after arming
        ramp_off = 0;
        start_run(1'b0, 1'b0, DW'(100), ModeNormal, HW'(3));
        cap.mode = ModeStop;
        feed(0, 1, DEPTH);
        idle(2);
        check_frame("normal");
        chk("normal first wrdata1", w1_q[base_w], 100);
        chk("normal last wraddr", wa_q[base_w+DEPTH-1], DEPTH - 1);
        chk("normal last wrdata1", w1_q[base_w+DEPTH-1], 227);
        chk("normal no back-to-back we", consec_cnt - base_consec, 0);
        holdoff_phase("normal", 3, StArmed);
        cap.abort = 1'b1;
        cyc();
        cap.abort = 1'b0;
        chk("abort from ARMED", cap.state_o, StIdle);

        // Falling edge on ch2
        n_high = int'($urandom_range(3, 20));
        start_run(1'b1, 1'b1, DW'(128), ModeNormal, HW'(7));
        feed(1, -1, DEPTH);
        idle(2);
        check_frame("falling");
        chk("falling first wrdata2", w2_q[base_w], 50);
        cap.abort = 1'b1;
        cyc();
        cap.abort = 1'b0;

        // Auto mode with a level that is never crossed
        start_run(1'b0, 1'b0, DW'(300), ModeAuto, HW'(2));
        feed(2, -1, DEPTH);
        idle(2);
        check_frame("auto");
        cap.abort = 1'b1;
        cyc();
        cap.abort = 1'b0;

        // Single mode, holdoff 5, then a second arm
        ramp_off = int'($urandom_range(0, 511));
        start_run(1'b0, 1'b0, DW'($urandom_range(1, 511)), ModeSingle, HW'(5));
        feed(0, -1, DEPTH);
        idle(2);
        check_frame("single");
        holdoff_phase("single", 5, StIdle);
        idle(3);
        chk("single stays idle", cap.state_o, StIdle);

        // Re-arm, then abort (with a simultaneous arm) while address 320 is being written
        ramp_off = int'($urandom_range(0, 511));
        start_run(1'b0, 1'b0, DW'($urandom_range(1, 511)), ModeSingle, HW'(5));
        feed(0, -1, 321);
        chk("pre-abort we", cap.we, 1);
        chk("pre-abort wraddr", cap.wraddr, 320);
        cap.abort = 1'b1;
        cap.arm = 1'b1;
        cap.sample_valid = 1'b1;
        cyc();
        cap.abort = 1'b0;
        cap.arm = 1'b0;
        cap.sample_valid = 1'b0;
        chk("abort we", cap.we, 0);
        chk("abort wraddr", cap.wraddr, 0);
        chk("abort state", cap.state_o, StIdle);
        chk("abort frame_done", cap.frame_done, 0);
        idle(3);
        chk("abort no frame_done pulses", done_cnt - base_done, 0);
        chk("abort writes up to 320", wa_q.size() - base_w, 321);

        // Asynchronous reset between edges during capture
        ramp_off = int'($urandom_range(0, 511));
        start_run(1'b0, 1'b0, DW'($urandom_range(1, 511)), ModeNormal, HW'(1));
        feed(0, 0, 50);
        chk("pre-reset state capture", cap.state_o, StCapture);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst we", cap.we, 0);
        chk("async rst wraddr", cap.wraddr, 0);
        chk("async rst wrdata1", cap.wrdata1, 0);
        chk("async rst state", cap.state_o, StIdle);
        chk("async rst triggered", cap.triggered, 0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cap.sample_valid = 1'b1;
            cap.ch1_in = DW'(i * 90);
            cap.ch2_in = DW'($urandom);
            cyc();
            chk("post-rst idle state", cap.state_o, StIdle);
            chk("post-rst idle we", cap.we, 0);
        end
        cap.sample_valid = 1'b0;
        start_run(1'b0, 1'b0, DW'(100), ModeNormal, HW'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Trigger and capture controller that sequences sample writes into the VDU's two trace buffers.
- Replaces the free-running write-address counter: it waits for a trigger on a selected channel, then writes exactly DEPTH sample pairs at addresses 0..DEPTH-1, then enters a hold-off period before re-arming.
- Sits between the sample sources (ROMs/ADC, paced by sample_valid) and the VDU write ports (wraddr1/2, wrdata1/2, we1/2, wclk1/2 = sclk).

Parameters:
- DEPTH, 640, samples per frame (trace width in pixels)
- AW, 10, write address width; must satisfy 2^AW >= DEPTH
- DW, 9, sample width per channel
- AUTO_TIMEOUT, 2048, accepted samples without a trigger before auto mode forces a capture
- HW, 16, width of the hold-off counter

Ports:
- sclk  in  1  sampling clock; all state changes on its rising edge
- rst  in  1  asynchronous active-high reset
- sample_valid  in  1  a new sample pair is present this cycle
- ch1_in  in  DW  channel 1 sample, unsigned
- ch2_in  in  DW  channel 2 sample, unsigned
- trig_level  in  DW  trigger threshold, unsigned
- trig_src  in  1  0 = trigger on ch1, 1 = trigger on ch2
- trig_slope  in  1  0 = rising, 1 = falling
- mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = stop
- arm  in  1  single-cycle pulse; starts a run from IDLE
- abort  in  1  returns to IDLE immediately
- holdoff  in  HW  number of accepted samples to skip after each frame
- wraddr  out  AW  trace buffer write address (shared by both VDU ports)
- wrdata1  out  DW  channel 1 write data
- wrdata2  out  DW  channel 2 write data
- we  out  1  write strobe to both VDU ports
- state_o  out  2  current state encoding
- triggered  out  1  high during CAPTURE when the frame was started by a real trigger
- frame_done  out  1  one-cycle pulse after the last write of a frame

Behaviour:
- Reset (async): state=IDLE; wraddr=0, wrdata1/2=0, we=0, triggered=0, frame_done=0; all counters=0; prev_valid=0.
- States:
  - IDLE=0: no writes. arm with mode!=3 -> ARMED. mode is latched at this transition and is not re-sampled until the next entry to ARMED from IDLE.
  - ARMED=1: on each accepted sample, compute prev/cur on the selected channel.
    - Rising trigger: prev_valid && prev<trig_level && cur>=trig_level.
    - Falling trigger: prev_valid && prev>=trig_level && cur<trig_level.
    - The first sample after entering ARMED only loads prev.
    - Trigger -> CAPTURE with triggered=1; the triggering sample is written at address 0.
    - Auto mode only: timeout counter increments per accepted sample; when it reaches AUTO_TIMEOUT-1 without a trigger, that sample starts the capture with triggered=0.
  - CAPTURE=2: each accepted sample is written at the next address. After address DEPTH-1 is written, wraddr wraps to 0, frame_done pulses 1 cycle, and state goes to HOLDOFF.
  - HOLDOFF=3: count accepted samples up to holdoff, with no writes. On reaching it: single mode -> IDLE; otherwise -> ARMED with prev_valid cleared. holdoff=0 exits on the cycle after entry.
- Write timing: a sample accepted at edge N produces registered we=1 with wraddr/wrdata valid for exactly the cycle after edge N. we is never high for 2 consecutive cycles unless sample_valid is high on consecutive cycles. Data is held when we=0.
- Samples without sample_valid are ignored in every state.
- abort has priority over all other inputs. Next edge: state=IDLE, we=0, wraddr=0, counters cleared, no frame_done. A partially written frame is left in the buffer.
- arm outside IDLE is ignored. arm and abort in the same cycle: abort wins.
- Trigger comparisons are unsigned full-width DW. Counters saturate and never wrap into false triggers.

Decomposition:
- Shared package scope_pkg holds:
  - the state encoding constants (IDLE/ARMED/CAPTURE/HOLDOFF)
  - the mode constants (AUTO/NORMAL/SINGLE/STOP)
  - the DEPTH/AW/DW defaults, shared with the VDU
- One natural sub-module: trig_detect. It holds the prev register, prev_valid, and the slope/level compare, and outputs a single-cycle hit.

Test Plan:
- Normal mode, rising edge: ch1 ramps 0..511 step 1 with sample_valid every other cycle, trig_level=100 -> first we carries wraddr=0, wrdata1=100. There are exactly 640 we pulses; the last has wraddr=639, wrdata1=739 mod 512 = 227. frame_done pulses once.
- Falling, ch2 source: ch2 steps 200->50, trig_level=128, trig_slope=1 -> capture starts at the 50 sample; triggered=1.
- Auto mode: constant input 10, trig_level=300 -> after 2048 accepted samples, capture starts with triggered=0 and 640 writes follow.
- Single mode, holdoff=5: after frame_done, exactly 5 accepted samples pass with no we, then state_o=0. A second arm restarts the run.
- Abort at wraddr=320: next cycle we=0, wraddr=0, state_o=0, and no frame_done pulse.
- Async rst asserted mid-CAPTURE, between clock edges: outputs go to zero immediately. After release, the block stays in IDLE until arm.
